operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Decode-to-execute operand stage; sits directly upstream of the EX stage and beside the 16x16 register file.
//  Drives the register file read addresses and takes RData1/RData2.
//  Resolves operand forwarding from the EX/MEM and MEM/WB stages, and detects RAW hazards.
//  Registers one instruction into the ID/EX pipeline register, using a valid/ready handshake and bubble insertion.
// PARAMETERS
//  DSIZE   16  data width (matches `DSIZE)
//  RSIZE   4   register address width (matches `RSIZE); R0 is hard zero
//  OPSIZE  4   opcode width
// PORTS
//  Clock       in   1       clock; all state updates on posedge
//  Reset       in   1       synchronous reset, active-low
//  id_valid    in   1       decode presents an instruction
//  id_ready    out  1       this stage accepts the instruction this cycle
//  id_op       in   OPSIZE  opcode
//  id_rs1      in   RSIZE   source register 1
//  id_rs2      in   RSIZE   source register 2
//  id_rd       in   RSIZE   destination register
//  id_we       in   1       instruction writes rd
//  id_is_load  in   1       instruction is a load
//  RAddr1      out  RSIZE   register file read address 1; combinationally = id_rs1
//  RAddr2      out  RSIZE   register file read address 2; combinationally = id_rs2
//  RData1      in   DSIZE   register file read data 1 (no internal bypass in the register file)
//  RData2      in   DSIZE   register file read data 2 (no internal bypass in the register file)
//  exm_we      in   1       EX/MEM write enable
//  exm_is_load in   1       EX/MEM instruction is a load
//  exm_rd      in   RSIZE   EX/MEM destination register
//  exm_data    in   DSIZE   EX/MEM ALU result
//  wb_we       in   1       MEM/WB write enable (also the register file Wen)
//  wb_rd       in   RSIZE   MEM/WB destination register
//  wb_data     in   DSIZE   MEM/WB write data
//  flush       in   1       branch taken: kill the younger instruction
//  ex_ready    in   1       EX stage can accept
//  ex_valid    out  1       ID/EX register holds a live instruction
//  ex_op       out  OPSIZE  ID/EX opcode
//  ex_rd       out  RSIZE   ID/EX destination register
//  ex_we       out  1       ID/EX write enable
//  ex_is_load  out  1       ID/EX is-load flag
//  ex_a        out  DSIZE   resolved operand A
//  ex_b        out  DSIZE   resolved operand B
// BEHAVIOUR
//  Reset low at posedge: every ex_* output is 0, including ex_valid. id_ready=0 while Reset is low.
//  Reset also overrides an in-flight handshake.
//  adv = !ex_valid | ex_ready. When adv is 0, the ID/EX register holds and id_ready is 0.
//  Source match for rsN (N=1,2): rsN != 0 and the producer's we=1 and the producer's rd == rsN.
//  Hazard (stall) if, for any source, either condition holds:
//   (a) it matches the ID/EX register (ex_valid & ex_we & ex_rd==rsN); this result is not yet computed.
//   (b) it matches EX/MEM while exm_is_load=1; the load data is not yet available.
//   (c) Only with WB_BYPASS_EN undefined: it matches MEM/WB.
//  Operand select, highest priority first:
//   rsN==0 -> 0;
//   EX/MEM match (not a load) -> exm_data;
//   MEM/WB match (WB_BYPASS_EN only) -> wb_data;
//   otherwise RDataN.
//  id_ready = Reset & adv & (!hazard | flush).
//  Posedge with adv=1:
//   flush=1 -> ex_valid<=0; the incoming instruction is consumed and dropped.
//   id_valid & !hazard -> load the instruction; ex_valid<=1.
//   otherwise -> bubble; ex_valid<=0 and the other ex_* fields hold.
//  Latency: 1 cycle from acceptance to ex_valid. Each stall costs 1 bubble per cycle while the hazard persists.
//  flush with adv=0: ex_valid<=0 anyway, because flush kills the held instruction.
//  Simultaneous hazard and flush: flush wins.
// CONFIGURATION
//  WB_BYPASS_EN defined: MEM/WB data is forwarded and a MEM/WB match never stalls.
//  WB_BYPASS_EN undefined: a MEM/WB match stalls 1 cycle. The read is retried after the register file write.
// STRUCTURE
//  Shared define.v holds DSIZE, RSIZE, OPSIZE and the opcode constants (LOAD, etc.).
//  Sub-module operand_sel: forwarding compare plus mux plus per-operand hazard flag; instantiated twice (rs1, rs2).
//  operand_fetch holds the handshake and the ID/EX register.
// TESTING
//  1. Reset=0 for 2 cycles with id_valid=1 -> ex_valid=0, ex_a=ex_b=0, id_ready=0.
//  2. rs1=3, rs2=0, RData1=0x1234, no producers -> next cycle ex_valid=1, ex_a=0x1234, ex_b=0.
//  3. EX/MEM we=1, rd=5, data=0x00AA, not a load; id rs1=5 -> ex_a=0x00AA with no stall.
//  4. ID/EX holds a load with rd=2; next instruction has rs2=2 -> one bubble (ex_valid=0, id_ready=0).
//     Then EX/MEM is_load blocks for a second cycle; the instruction issues once data arrives via MEM/WB.
//  5. wb_we=1, rd=7, data=0xBEEF; id rs1=7 -> with WB_BYPASS_EN: ex_a=0xBEEF at once.
//     Without it: 1 bubble, then ex_a = RData1 = 0xBEEF.
//  6. ex_valid=1, ex_ready=0 for 3 cycles -> ex_* stable and id_ready=0.
//     Then flush=1 -> ex_valid=0 next cycle and the incoming instruction is dropped.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared widths, opcodes and the ID/EX register layout for the operand fetch stage.
// The WB_BYPASS_EN build macro is consumed by operand_sel; it adds MEM/WB forwarding.
package operand_fetch_pkg;
  localparam int DSIZE  = 16;
  localparam int RSIZE  = 4;
  localparam int OPSIZE = 4;
  localparam int NSRC   = 2;

  typedef enum logic [OPSIZE-1:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_LOAD  = 4'h8,
    OP_STORE = 4'h9,
    OP_BR    = 4'hC
  } opcode_e;

  typedef struct packed {
    logic [OPSIZE-1:0] op;
    logic [RSIZE-1:0]  rd;
    logic              we;
    logic              is_load;
    logic [DSIZE-1:0]  a;
    logic [DSIZE-1:0]  b;
  } idex_t;

  function automatic logic src_match(input logic [RSIZE-1:0] rs, input logic we,
                                     input logic [RSIZE-1:0] rd);
    return (rs != '0) && we && (rd == rs);
  endfunction
endpackage

// File: rtl/operand_fetch_sel.sv
// Per-source forwarding compare, operand mux and hazard flag (module operand_sel).
// WB_BYPASS_EN defined: MEM/WB data is forwarded; undefined: a MEM/WB match stalls.
module operand_sel
  import operand_fetch_pkg::*;
(
  input  logic [RSIZE-1:0] rs,
  input  logic [DSIZE-1:0] rdata,
  input  logic             idex_valid,
  input  logic             idex_we,
  input  logic [RSIZE-1:0] idex_rd,
  input  logic             exm_we,
  input  logic             exm_is_load,
  input  logic [RSIZE-1:0] exm_rd,
  input  logic [DSIZE-1:0] exm_data,
  input  logic             wb_we,
  input  logic [RSIZE-1:0] wb_rd,
  input  logic [DSIZE-1:0] wb_data,
  output logic [DSIZE-1:0] opnd,
  output logic             hazard
);
  logic m_idex, m_exm, m_wb;

  assign m_idex = src_match(rs, idex_valid & idex_we, idex_rd);
  assign m_exm  = src_match(rs, exm_we, exm_rd);
  assign m_wb   = src_match(rs, wb_we, wb_rd);

`ifdef WB_BYPASS_EN
  assign hazard = m_idex | (m_exm & exm_is_load);

  always_comb begin
    opnd = rdata;
    if (rs == '0)                   opnd = '0;
    else if (m_exm && !exm_is_load) opnd = exm_data;
    else if (m_wb)                  opnd = wb_data;
  end
`else
  // Register file has no write-through, so a MEM/WB match waits for the write.
  assign hazard = m_idex | (m_exm & exm_is_load) | m_wb;

  always_comb begin
    opnd = rdata;
    if (rs == '0)                   opnd = '0;
    else if (m_exm && !exm_is_load) opnd = exm_data;
  end
`endif
endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage: register file read, forwarding, RAW stall and ID/EX register.
// Build option WB_BYPASS_EN (see operand_sel) enables MEM/WB forwarding.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [OPSIZE-1:0] id_op,
  input  logic [RSIZE-1:0]  id_rs1,
  input  logic [RSIZE-1:0]  id_rs2,
  input  logic [RSIZE-1:0]  id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  output logic [RSIZE-1:0]  RAddr1,
  output logic [RSIZE-1:0]  RAddr2,
  input  logic [DSIZE-1:0]  RData1,
  input  logic [DSIZE-1:0]  RData2,
  input  logic              exm_we,
  input  logic              exm_is_load,
  input  logic [RSIZE-1:0]  exm_rd,
  input  logic [DSIZE-1:0]  exm_data,
  input  logic              wb_we,
  input  logic [RSIZE-1:0]  wb_rd,
  input  logic [DSIZE-1:0]  wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [OPSIZE-1:0] ex_op,
  output logic [RSIZE-1:0]  ex_rd,
  output logic              ex_we,
  output logic              ex_is_load,
  output logic [DSIZE-1:0]  ex_a,
  output logic [DSIZE-1:0]  ex_b
);
  logic [NSRC-1:0][RSIZE-1:0] rs;
  logic [NSRC-1:0][DSIZE-1:0] rdata, opnd;
  logic [NSRC-1:0]            haz;
  logic                       hazard, adv;
  logic                       vld_q;
  idex_t                      idex_q;

  assign RAddr1 = id_rs1;
  assign RAddr2 = id_rs2;
  assign rs     = {id_rs2, id_rs1};
  assign rdata  = {RData2, RData1};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    operand_sel u_sel (
      .rs          (rs[g]),
      .rdata       (rdata[g]),
      .idex_valid  (vld_q),
      .idex_we     (idex_q.we),
      .idex_rd     (idex_q.rd),
      .exm_we      (exm_we),
      .exm_is_load (exm_is_load),
      .exm_rd      (exm_rd),
      .exm_data    (exm_data),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .opnd        (opnd[g]),
      .hazard      (haz[g])
    );
  end

  assign hazard   = |haz;
  assign adv      = !vld_q | ex_ready;
  // A flush consumes the incoming instruction even when it would otherwise stall.
  assign id_ready = Reset & adv & (!hazard | flush);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      vld_q  <= 1'b0;
      idex_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (adv) begin
      if (id_valid && !hazard) begin
        vld_q  <= 1'b1;
        idex_q <= '{op: id_op, rd: id_rd, we: id_we, is_load: id_is_load,
                    a: opnd[0], b: opnd[1]};
      end else begin
        vld_q <= 1'b0;
      end
    end
  end

  assign ex_valid   = vld_q;
  assign ex_op      = idex_q.op;
  assign ex_rd      = idex_q.rd;
  assign ex_we      = idex_q.we;
  assign ex_is_load = idex_q.is_load;
  assign ex_a       = idex_q.a;
  assign ex_b       = idex_q.b;
endmodule
